shapool_spi_host: RTL

- SPI Mode 0 master that drives the two `external_io` SPI ports from the host/controller side.
- Three operations:
  - Shifts a job configuration out on SPI0.
  - Shifts a device configuration out on SPI1.
  - Clocks the result word (match flags + nonce) back in on SPI1.
- Used in the host-side FPGA bridge and as the bus-functional driver in system-level benches; replaces hand-written SPI bit-banging.

---
 rtl/shapool_spi_host.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/shapool_spi_host.sv
// SPI Mode 0 host for the shapool external_io ports.
// Three transfers: a job config goes out on SPI0, a device config goes out
// on SPI1, and a result word comes in on SPI1. Data moves MSB first. The
// slave changes its data on falling sck, and the host samples on rising sck.
module shapool_spi_host #(
    parameter int JOB_CONFIG_WIDTH    = 8,
    parameter int DEVICE_CONFIG_WIDTH = 8,
    parameter int RESULT_WIDTH        = 40,
    parameter int SCK_HALF_PERIOD     = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start_job,
    input  logic                           start_device,
    input  logic                           start_read,
    input  logic [JOB_CONFIG_WIDTH-1:0]    job_config_in,
    input  logic [DEVICE_CONFIG_WIDTH-1:0] device_config_in,
    output logic                           busy,
    output logic                           done,
    output logic [RESULT_WIDTH-1:0]        result_out,
    output logic                           result_valid,
    output logic                           sck0,
    output logic                           sdi0,
    output logic                           cs0_n,
    output logic                           sck1,
    output logic                           sdi1,
    output logic                           cs1_n,
    input  logic                           sdo1
);

    // The transmit register is shared by both config ports and left-aligned,
    // so its MSB is always the next bit on the wire.
    localparam int TX_W  = (JOB_CONFIG_WIDTH > DEVICE_CONFIG_WIDTH) ?
                           JOB_CONFIG_WIDTH : DEVICE_CONFIG_WIDTH;
    localparam int MAX_N = (TX_W > RESULT_WIDTH) ? TX_W : RESULT_WIDTH;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam int DIV_W = $clog2(SCK_HALF_PERIOD + 1);

    localparam logic [CNT_W-1:0] N_JOB  = CNT_W'(JOB_CONFIG_WIDTH);
    localparam logic [CNT_W-1:0] N_DEV  = CNT_W'(DEVICE_CONFIG_WIDTH);
    localparam logic [CNT_W-1:0] N_READ = CNT_W'(RESULT_WIDTH);

    // SETUP is loaded with the full half period. Because the load happens on
    // the accept edge, SETUP lasts one extra cycle. The other phases last
    // exactly one half period.
    localparam logic [DIV_W-1:0] DIV_SETUP = DIV_W'(SCK_HALF_PERIOD);
    localparam logic [DIV_W-1:0] DIV_PHASE = DIV_W'(SCK_HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   bits_left;
    logic [TX_W-1:0]    tx_sr;
    logic [RESULT_WIDTH-1:0] rx_sr;
    logic               on_spi1;
    logic               is_read;

    // Transfer sequencer. All SPI pins and status outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            div          <= '0;
            bits_left    <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            on_spi1      <= 1'b0;
            is_read      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
            sck0         <= 1'b0;
            sdi0         <= 1'b0;
            cs0_n        <= 1'b1;
            sck1         <= 1'b0;
            sdi1         <= 1'b0;
            cs1_n        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_job || start_device || start_read) begin
                        busy  <= 1'b1;
                        state <= SETUP;
                        div   <= DIV_SETUP;
                        if (start_job) begin
                            tx_sr     <= TX_W'(job_config_in) << (TX_W - JOB_CONFIG_WIDTH);
                            bits_left <= N_JOB;
                            on_spi1   <= 1'b0;
                            is_read   <= 1'b0;
                            cs0_n     <= 1'b0;
                            sdi0      <= job_config_in[JOB_CONFIG_WIDTH-1];
                        end else if (start_device) begin
                            tx_sr     <= TX_W'(device_config_in) << (TX_W - DEVICE_CONFIG_WIDTH);
                            bits_left <= N_DEV;
                            on_spi1   <= 1'b1;
                            is_read   <= 1'b0;
                            cs1_n     <= 1'b0;
                            sdi1      <= device_config_in[DEVICE_CONFIG_WIDTH-1];
                        end else begin
                            rx_sr        <= '0;
                            bits_left    <= N_READ;
                            on_spi1      <= 1'b1;
                            is_read      <= 1'b1;
                            cs1_n        <= 1'b0;
                            sdi1         <= 1'b0;
                            result_valid <= 1'b0;
                        end
                    end
                end
                SETUP, LOW: begin
                    if (div != '0) begin
                        div <= div - 1'b1;
                    end else begin
                        // Rising sck edge: the slave's bit has been stable for a
                        // half period, so it is safe to capture it now.
                        state     <= HIGH;
                        div       <= DIV_PHASE;
                        bits_left <= bits_left - 1'b1;
                        if (on_spi1) sck1 <= 1'b1;
                        else         sck0 <= 1'b1;
                        if (is_read) rx_sr <= {rx_sr[RESULT_WIDTH-2:0], sdo1};
                    end
                end
                HIGH: begin
                    if (div != '0) begin
                        div <= div - 1'b1;
                    end else begin
                        sck0 <= 1'b0;
                        sck1 <= 1'b0;
                        div  <= DIV_PHASE;
                        if (bits_left == '0) begin
                            state <= HOLD;
                        end else begin
                            // Falling sck edge: present the next bit.
                            state <= LOW;
                            tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
                            if (!is_read) begin
                                if (on_spi1) sdi1 <= tx_sr[TX_W-2];
                                else         sdi0 <= tx_sr[TX_W-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (div != '0) begin
                        div <= div - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cs0_n <= 1'b1;
                        cs1_n <= 1'b1;
                        sdi0  <= 1'b0;
                        sdi1  <= 1'b0;
                        if (is_read) begin
                            result_out   <= rx_sr;
                            result_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
